// File: rtl/trace_capture_buffer.sv
// Retire-trace capture buffer: records the commit stream into a circular buffer,
// stops a fixed number of entries after a PC-match trigger, then drains the window
// oldest-first through a valid/ready port.
// Optional build macro: TRACE_CYCLE_STAMP_EN adds a 32-bit cycle stamp to every entry.
module trace_capture_buffer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8,
`ifdef TRACE_CYCLE_STAMP_EN
  localparam int unsigned EW       = 2 * XLEN + 65,
`else
  localparam int unsigned EW       = 2 * XLEN + 33,
`endif
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cap_valid,
  input  logic [XLEN-1:0] cap_pc,
  input  logic [31:0]     cap_instr,
  input  logic [XLEN-1:0] cap_alu,
  input  logic            cap_we,
  input  logic            arm,
  input  logic            abort,
  input  logic [XLEN-1:0] trig_pc,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [EW-1:0]   rd_data,
  output logic [CW-1:0]   count,
  output logic [1:0]      state,
  output logic            trig_hit
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 4");
  end
  if (POST_TRIG >= DEPTH) begin : g_bad_post
    $error("POST_TRIG must be smaller than DEPTH");
  end

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] trig_pc_q, trig_pc_d;
  logic            trig_hit_q, trig_hit_d;
  logic            wr_en;
  logic            pop;
  logic [EW-1:0]   entry;
  logic [EW-1:0]   mem [DEPTH];

`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0] cyc_q;

  // Free-running cycle stamp, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_q + 32'd1;
  end

  assign entry = {cyc_q, cap_we, cap_alu, cap_instr, cap_pc};
`else
  assign entry = {cap_we, cap_alu, cap_instr, cap_pc};
`endif

  assign rd_valid = (state_q == StDone) && (count_q != '0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
  assign count    = count_q;
  assign state    = state_q;
  assign trig_hit = trig_hit_q;

  // Next-state logic: abort dominates, then the per-state capture/readout rules.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    trig_pc_d  = trig_pc_q;
    trig_hit_d = 1'b0;
    wr_en      = 1'b0;

    if (abort) begin
      state_d  = StIdle;
      count_d  = '0;
      rem_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_d   = StArmed;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            trig_pc_d = trig_pc;
          end
        end
        StArmed: begin
          if (cap_valid) begin
            wr_en = 1'b1;
            if (cap_pc == trig_pc_q) begin
              trig_hit_d = 1'b1;
              if (POST_TRIG == 0) begin
                state_d = StDone;
              end else begin
                state_d = StPost;
                rem_d   = CW'(POST_TRIG);
              end
            end
          end
        end
        StPost: begin
          if (cap_valid) begin
            wr_en = 1'b1;
            rem_d = rem_q - CW'(1);
            if (rem_q == CW'(1)) state_d = StDone;
          end
        end
        StDone: begin
          if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      // A write into a full buffer drops the oldest entry by advancing the read side.
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (count_q == CW'(DEPTH)) rd_ptr_d = rd_ptr_q + AW'(1);
        else                       count_d  = count_q + CW'(1);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      rem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      trig_pc_q  <= '0;
      trig_hit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      trig_pc_q  <= trig_pc_d;
      trig_hit_q <= trig_hit_d;
    end
  end

  // Entry storage; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_ptr_q] <= entry;
  end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Self-checking bench for trace_capture_buffer: constant vector table, directed
// multi-cycle sequences and a randomized phase, all checked against a queue model.
// Honours TRACE_CYCLE_STAMP_EN the same way as the design.
module tb_trace_capture_buffer;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned POST_TRIG = 8;
`ifdef TRACE_CYCLE_STAMP_EN
  localparam int unsigned EW = 2 * XLEN + 65;
`else
  localparam int unsigned EW = 2 * XLEN + 33;
`endif
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cap_valid = 1'b0;
  logic [XLEN-1:0] cap_pc = '0;
  logic [31:0]     cap_instr = '0;
  logic [XLEN-1:0] cap_alu = '0;
  logic            cap_we = 1'b0;
  logic            arm = 1'b0;
  logic            abort = 1'b0;
  logic [XLEN-1:0] trig_pc = '0;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [EW-1:0]   rd_data;
  logic [CW-1:0]   count;
  logic [1:0]      state;
  logic            trig_hit;

  trace_capture_buffer #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .POST_TRIG (POST_TRIG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cap_valid (cap_valid),
    .cap_pc    (cap_pc),
    .cap_instr (cap_instr),
    .cap_alu   (cap_alu),
    .cap_we    (cap_we),
    .arm       (arm),
    .abort     (abort),
    .trig_pc   (trig_pc),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .count     (count),
    .state     (state),
    .trig_hit  (trig_hit)
  );

  always #5 clk = ~clk;

  int nrun  = 0;
  int nfail = 0;
  int hits  = 0;
  logic [31:0] salt = 32'h0;

  // Reference model: the captured window is just a bounded queue.
  int              m_mode = 0;  // 0 idle, 1 armed, 2 post, 3 done
  logic [EW-1:0]   m_q[$];
  int              m_rem = 0;
  bit              m_hit = 1'b0;
  logic [XLEN-1:0] m_tpc = '0;
  logic [31:0]     m_cyc = '0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    nrun++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_push(input logic [EW-1:0] e);
    m_q.push_back(e);
    if (m_q.size() > DEPTH) void'(m_q.pop_front());
  endtask

  task automatic model_edge();
    logic [EW-1:0] e;
`ifdef TRACE_CYCLE_STAMP_EN
    e = {m_cyc, cap_we, cap_alu, cap_instr, cap_pc};
`else
    e = {cap_we, cap_alu, cap_instr, cap_pc};
`endif
    if (reset) begin
      m_mode = 0;
      m_q.delete();
      m_hit  = 1'b0;
      m_rem  = 0;
      m_tpc  = '0;
      m_cyc  = '0;
    end else begin
      m_cyc = m_cyc + 32'd1;
      m_hit = 1'b0;
      if (abort) begin
        m_mode = 0;
        m_q.delete();
      end else begin
        case (m_mode)
          0: if (arm) begin
            m_mode = 1;
            m_q.delete();
            m_tpc = trig_pc;
          end
          1: if (cap_valid) begin
            m_push(e);
            if (cap_pc == m_tpc) begin
              m_hit = 1'b1;
              if (POST_TRIG == 0) m_mode = 3;
              else begin
                m_mode = 2;
                m_rem  = POST_TRIG;
              end
            end
          end
          2: if (cap_valid) begin
            m_push(e);
            m_rem--;
            if (m_rem == 0) m_mode = 3;
          end
          default: if (m_q.size() > 0 && rd_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_mode = 0;
          end
        endcase
      end
    end
  endtask

  task automatic model_check();
    bit            v;
    logic [EW-1:0] d;
    v = (m_mode == 3) && (m_q.size() > 0);
    d = v ? m_q[0] : '0;
    chk("m_state", state, m_mode[1:0]);
    chk("m_count", count, m_q.size());
    chk("m_rd_valid", rd_valid, v);
    chk("m_rd_data", rd_data, d);
    chk("m_trig_hit", trig_hit, m_hit);
  endtask

  // One clock: drive inputs, take the edge, update model, compare #1 later.
  task automatic step(input logic r, input logic a, input logic ab, input logic v,
                      input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tpc,
                      input logic rdy);
    reset     = r;
    arm       = a;
    abort     = ab;
    cap_valid = v;
    cap_pc    = pc;
    cap_instr = pc[31:0] ^ salt;
    cap_alu   = pc * 7 + XLEN'(salt);
    cap_we    = pc[2] ^ salt[0];
    trig_pc   = tpc;
    rd_ready  = rdy;
    @(posedge clk);
    model_edge();
    #1;
    model_check();
    if (trig_hit) hits++;
  endtask

  task automatic feed(input logic [XLEN-1:0] base, input int n, input bit gapped);
    int idx = 0;
    for (int c = 0; c < 4 * n && idx < n; c++) begin
      if (gapped && c[0]) step(0, 0, 0, 0, '0, '0, 0);
      else begin
        step(0, 0, 0, 1, base + XLEN'(4 * idx), '0, 0);
        idx++;
      end
    end
  endtask

  task automatic drain(input int n_exp, input logic [XLEN-1:0] base, input bit bp,
                       input string tag);
    int  n = 0;
    logic rdy;
    for (int c = 0; c < 50 * n_exp && n < n_exp; c++) begin
      rdy = bp ? 1'($urandom % 2) : 1'b1;
      if (rd_valid) chk({tag, "_pc"}, rd_data[XLEN-1:0], base + XLEN'(4 * n));
      if (rd_valid && rdy) n++;
      step(0, 0, 0, 0, '0, '0, rdy);
    end
    chk({tag, "_popped"}, n, n_exp);
    chk({tag, "_idle"}, state, 2'd0);
    chk({tag, "_rd_valid_low"}, rd_valid, 1'b0);
  endtask

  typedef struct {
    logic            a;
    logic            ab;
    logic            v;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tpc;
    logic [1:0]      exp_state;
    int              exp_count;
    logic            exp_hit;
  } vec_t;

  vec_t vt[11];

  initial begin
    // Control corner cases with hand-computed expectations (POST_TRIG = 8).
    vt[0]  = '{1, 1, 0, 'h0,   'h100, 0, 0, 0};  // arm+abort: stays idle
    vt[1]  = '{0, 0, 1, 'h10,  'h0,   0, 0, 0};  // capture ignored in idle
    vt[2]  = '{1, 0, 0, 'h0,   'h100, 1, 0, 0};  // arm
    vt[3]  = '{0, 0, 1, 'h0,   'h0,   1, 1, 0};
    vt[4]  = '{0, 0, 0, 'h100, 'h0,   1, 1, 0};  // matching PC but not valid
    vt[5]  = '{1, 0, 1, 'h4,   'h4,   1, 2, 0};  // arm ignored while armed
    vt[6]  = '{0, 0, 1, 'h100, 'h0,   2, 3, 1};  // trigger
    vt[7]  = '{0, 0, 0, 'h0,   'h0,   2, 3, 0};
    vt[8]  = '{0, 0, 1, 'h100, 'h0,   2, 4, 0};  // re-match ignored in post
    vt[9]  = '{0, 1, 1, 'h8,   'h0,   0, 0, 0};  // abort wins over capture
    vt[10] = '{0, 0, 1, 'h100, 'h0,   0, 0, 0};

    step(1, 0, 0, 0, '0, '0, 0);
    step(1, 0, 0, 0, '0, '0, 0);
    chk("por_state", state, 2'd0);
    chk("por_count", count, 0);
    chk("por_rd_valid", rd_valid, 1'b0);
    chk("por_rd_data", rd_data, '0);

    for (int i = 0; i < 11; i++) begin
      step(0, vt[i].a, vt[i].ab, vt[i].v, vt[i].pc, vt[i].tpc, 1);
      chk($sformatf("vec%0d_state", i), state, vt[i].exp_state);
      chk($sformatf("vec%0d_count", i), count, vt[i].exp_count);
      chk($sformatf("vec%0d_hit", i), trig_hit, vt[i].exp_hit);
    end

    // Mid-stream reset.
    step(0, 1, 0, 0, '0, 'h8, 0);
    feed('h0, 3, 0);
    step(1, 0, 0, 1, 'h10, '0, 0);
    step(1, 0, 0, 1, 'h14, '0, 0);
    chk("rst_state", state, 2'd0);
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_trig_hit", trig_hit, 1'b0);

    // Wrap then trigger.
    salt = 32'h1234_5678;
    step(0, 1, 0, 0, '0, 'h40, 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 1, XLEN'(4 * i), '0, 0);
      if (i == 24) chk("wrap_done_at_0x60", state, 2'd3);
    end
    chk("wrap_count", count, 16);
    drain(16, 'h24, 0, "wrap");

    // Early trigger, contiguous and gapped, second with backpressure.
    for (int g = 0; g < 2; g++) begin
      hits = 0;
      step(0, 1, 0, 0, '0, 'h8, 0);
      feed('h0, 20, g[0]);
      chk($sformatf("early%0d_count", g), count, 11);
      chk($sformatf("early%0d_state", g), state, 2'd3);
      chk($sformatf("early%0d_hits", g), hits, 1);
      drain(11, 'h0, g[0], $sformatf("early%0d", g));
    end

    // Abort in POST with 12 held, then re-arm with fresh data.
    step(0, 1, 0, 0, '0, 'h2C, 0);
    feed('h0, 12, 0);
    chk("abort_pre_state", state, 2'd2);
    chk("abort_pre_count", count, 12);
    step(0, 0, 1, 1, 'h30, '0, 0);
    chk("abort_state", state, 2'd0);
    chk("abort_count", count, 0);
    step(0, 1, 0, 0, '0, 'h1000, 0);
    feed('h1000, 12, 0);
    chk("rearm_count", count, 9);
    drain(9, 'h1000, 1, "rearm");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      salt = $urandom;
      step(1'($urandom % 300 == 0), 1'($urandom % 4 == 0), 1'($urandom % 80 == 0),
           1'($urandom % 3 != 0), XLEN'(4 * ($urandom % 24)), XLEN'(4 * ($urandom % 24)),
           1'($urandom % 2));
    end

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule

// File: doc/trace_capture_buffer.md
# trace_capture_buffer

Parametrised retire-trace capture buffer for the single-cycle RISC-V core. It watches the per-cycle commit stream: PC, instruction, ALU result and register-write enable. It records those entries into a circular buffer, stops a programmable number of entries after a PC-match trigger, and drains the window oldest-first through a valid/ready port. It sits beside `processor` and taps the same internal signals the bench prints today, so a bench or debug host can collect a bounded pre/post-trigger history instead of an unbounded print log.

## Interface
- `XLEN`, 32, PC and ALU-result width
- `DEPTH`, 16, number of stored entries; must be a power of two and at least 4
- `POST_TRIG`, 8, valid entries captured after the trigger entry; must satisfy 0 ≤ POST_TRIG < DEPTH (elaboration error otherwise)
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `cap_valid`  in  1  current cycle is a retiring instruction
- `cap_pc`  in  XLEN  retiring PC
- `cap_instr`  in  32  retiring instruction word
- `cap_alu`  in  XLEN  ALU result
- `cap_we`  in  1  register-file write enable
- `arm`  in  1  start capture; honoured only in IDLE
- `abort`  in  1  return to IDLE from any state and discard contents
- `trig_pc`  in  XLEN  trigger PC; sampled when `arm` is accepted
- `rd_valid`  out  1  `rd_data` holds an entry
- `rd_ready`  in  1  consumer accepts `rd_data`
- `rd_data`  out  EW  entry `{cap_we, cap_alu, cap_instr, cap_pc}`; EW = 2·XLEN+33, plus 32 bits when the cycle-stamp feature is built
- `count`  out  $clog2(DEPTH+1)  entries currently held
- `state`  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- `trig_hit`  out  1  single-cycle pulse, registered, in the cycle after the trigger entry is written

## Operation
- IDLE: no capture. `arm` clears `count` and the pointers, latches `trig_pc`, and moves to ARMED.
- ARMED: every `cap_valid` cycle writes an entry at `wr_ptr` and increments `wr_ptr` modulo DEPTH. `count` saturates at DEPTH; once full, each new write overwrites the oldest entry and advances `rd_ptr` with it.
- Trigger: `cap_valid && cap_pc == trig_pc` while in ARMED. The trigger entry itself is stored. If POST_TRIG=0 the next state is DONE, otherwise POST with a remaining-count of POST_TRIG.
- POST: capture continues with the same overwrite rule. Each valid write decrements the remaining-count; the write that takes it to 0 moves the state to DONE. Further PC matches are ignored.
- DONE: no capture. `rd_valid` = (`count` ≠ 0). `rd_data` is the entry at `rd_ptr`, shown ahead and combinational from storage. A pop (`rd_valid && rd_ready`) increments `rd_ptr` and decrements `count`. The pop that takes `count` to 0 moves the state to IDLE.
- `abort` has priority over every other event: next state IDLE, `count`=0, `rd_valid`=0.
- `arm` outside IDLE is ignored. `arm` and `abort` in the same cycle: `abort` wins and the block stays in IDLE.
- `cap_valid` low cycles are ignored in every state.

## Timing
- Reset values: `state`=IDLE, `count`=0, `rd_valid`=0, `trig_hit`=0, and `rd_data`=0 (output gated while `rd_valid` is low). Pointers and the remaining-count are cleared to 0.
- Capture latency: an entry presented at edge N is counted in `count` after edge N.
- The transition to DONE occurs on the same edge as the final post-trigger write. `rd_valid` rises in the following cycle.
- Readout sustains one pop per cycle with no bubbles. `rd_data` must hold stable while `rd_valid && !rd_ready`.
- `reset` asserted mid-capture or mid-readout behaves exactly like power-on reset on the next edge.

## Configuration
- `TRACE_CYCLE_STAMP_EN` defined: a free-running 32-bit cycle counter, cleared by `reset` and wrapping at 2^32, is stored in the top 32 bits of every entry. `rd_data` width is 2·XLEN+65.
- `TRACE_CYCLE_STAMP_EN` undefined: no counter is built and `rd_data` width is 2·XLEN+33.

## Test plan
- Reset: hold `reset` for 2 cycles mid-stream → `state`=0, `count`=0, `rd_valid`=0, `trig_hit`=0.
- Wrap then trigger: DEPTH=16, POST_TRIG=8, `trig_pc`=0x40. Arm and feed 40 consecutive valid PCs 0x0, 0x4, 0x8, … → DONE after the PC 0x60 write, `count`=16, readout yields 0x24…0x60 in steps of 4, then IDLE.
- Early trigger: `trig_pc`=0x8, feed 20 PCs from 0x0 → `count`=11, readout yields 0x0…0x28, `trig_hit` pulses once.
- Gapped capture: the same stream as the early-trigger case with `cap_valid` low every other cycle → identical stored contents and `count`.
- Backpressure: toggle `rd_ready` pseudo-randomly during readout → every entry is delivered exactly once and in order, `rd_data` stays stable while stalled, and the block is in IDLE after the last pop.
- Abort: assert `abort` in POST with `count`=12 → next cycle `state`=IDLE, `count`=0. A re-arm captures fresh data. With `TRACE_CYCLE_STAMP_EN` defined, consecutive-cycle entries carry stamps that differ by exactly 1.
